// File: rtl/mul_8bit_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational 8x8 multiplier between two requesters.
// Define MUL_OVF_EN to add the rsp_ovf flag (product does not fit in 8 bits).
module mul_8bit_arbiter #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [15:0] rsp_product,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    input  logic [15:0] mul_product,
    output logic        busy,
    output logic [1:0]  dbg_state
`ifdef MUL_OVF_EN
    ,
    output logic        rsp_ovf
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_cnt;
    logic        r_owner;
    logic        r_last_gnt;
    logic [7:0]  r_mul_a;
    logic [7:0]  r_mul_b;
    logic [15:0] r_rsp_product;
    logic        w_gnt0;
    logic        w_gnt1;

    // Handshake: a request transfers in the cycle where valid and ready are both high.
    // Ready is only offered in IDLE, to one requester, and depends combinationally on valid;
    // a requester that drops valid before seeing ready leaves no trace.
    always_comb begin
        w_next_state = r_state;
        w_gnt0       = 1'b0;
        w_gnt1       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_gnt0 = req0_valid && (!req1_valid || r_last_gnt);
                w_gnt1 = req1_valid && (!req0_valid || !r_last_gnt);
                if (w_gnt0 || w_gnt1) begin
                    w_next_state = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // last_gnt resets to requester 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt         <= 4'd0;
            r_owner       <= 1'b0;
            r_last_gnt    <= 1'b1;
            r_mul_a       <= 8'd0;
            r_mul_b       <= 8'd0;
            r_rsp_product <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_mul_a    <= w_gnt1 ? req1_a : req0_a;
                        r_mul_b    <= w_gnt1 ? req1_b : req0_b;
                        r_owner    <= w_gnt1;
                        r_last_gnt <= w_gnt1;
                        r_cnt      <= CNT_INIT;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_rsp_product <= mul_product;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MUL_OVF_EN
    logic r_rsp_ovf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp_ovf <= 1'b0;
        end else if (r_state == ST_SETTLE && r_cnt == 4'd0) begin
            r_rsp_ovf <= |mul_product[15:8];
        end
    end

    assign rsp_ovf = r_rsp_ovf;
`endif

    assign req0_ready  = w_gnt0;
    assign req1_ready  = w_gnt1;
    assign rsp0_valid  = (r_state == ST_RESP) && !r_owner;
    assign rsp1_valid  = (r_state == ST_RESP) && r_owner;
    assign rsp_product = r_rsp_product;
    assign mul_a       = r_mul_a;
    assign mul_b       = r_mul_b;
    assign busy        = (r_state != ST_IDLE);
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_mul_8bit_arbiter.sv
// Bench for mul_8bit_arbiter: timeline-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized two-requester traffic.
module tb_mul_8bit_arbiter;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0;
    logic        req0_ready;
    logic [7:0]  req0_a = 8'd0;
    logic [7:0]  req0_b = 8'd0;
    logic        req1_valid = 1'b0;
    logic        req1_ready;
    logic [7:0]  req1_a = 8'd0;
    logic [7:0]  req1_b = 8'd0;
    logic        rsp0_valid;
    logic        rsp1_valid;
    logic [15:0] rsp_product;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic [15:0] mul_product;
    logic        busy;
    logic [1:0]  dbg_state;
`ifdef MUL_OVF_EN
    logic        rsp_ovf;
`endif

    mul_8bit_arbiter #(.SETTLE_CYCLES(S)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_a(req0_a),
        .req0_b(req0_b),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_a(req1_a),
        .req1_b(req1_b),
        .rsp0_valid(rsp0_valid),
        .rsp1_valid(rsp1_valid),
        .rsp_product(rsp_product),
        .mul_a(mul_a),
        .mul_b(mul_b),
        .mul_product(mul_product),
        .busy(busy),
        .dbg_state(dbg_state)
`ifdef MUL_OVF_EN
        ,
        .rsp_ovf(rsp_ovf)
`endif
    );

    // The shared multiplier itself
    assign mul_product = 16'(mul_a) * 16'(mul_b);

    // ---------------- clock / reset / counters ----------------
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc_n    = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, errors=%0d", n_errs);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // ---------------- requester drivers ----------------
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic        hs0 = 1'b0;
    logic        hs1 = 1'b0;
    logic        wd_en = 1'b0;

    always @(posedge clk) begin
        #1;
        if (hs0) begin
            if (q0.size() > 0) {req0_a, req0_b} = q0.pop_front();
            else req0_valid = 1'b0;
        end else if (req0_valid && wd_en && $urandom_range(0, 9) == 0) begin
            req0_valid = 1'b0;
        end else if (!req0_valid && q0.size() > 0) begin
            {req0_a, req0_b} = q0.pop_front();
            req0_valid = 1'b1;
        end
        if (hs1) begin
            if (q1.size() > 0) {req1_a, req1_b} = q1.pop_front();
            else req1_valid = 1'b0;
        end else if (req1_valid && wd_en && $urandom_range(0, 9) == 0) begin
            req1_valid = 1'b0;
        end else if (!req1_valid && q1.size() > 0) begin
            {req1_a, req1_b} = q1.pop_front();
            req1_valid = 1'b1;
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    // Transaction timeline: accept at T -> response at T+S+1, next accept from T+S+2.
    int          m_idle_from = 0;
    int          m_rsp_at    = -1;
    int          m_owner     = 0;
    int          m_last      = 1;
    logic [15:0] m_prod      = 16'd0;
    logic [15:0] m_pend      = 16'd0;
    logic [7:0]  m_a         = 8'd0;
    logic [7:0]  m_b         = 8'd0;
    logic        m_ovf       = 1'b0;
    logic        m_pend_ovf  = 1'b0;

    always @(negedge clk) begin
        logic idle, e_r0, e_r1;
        hs0 = rst_n && req0_valid && req0_ready;
        hs1 = rst_n && req1_valid && req1_ready;
        if (!rst_n) begin
            m_idle_from = 0;
            m_rsp_at    = -1;
            m_last      = 1;
            m_prod      = 16'd0;
            m_a         = 8'd0;
            m_b         = 8'd0;
            m_ovf       = 1'b0;
        end else begin
            idle = (cyc_n >= m_idle_from);
            e_r0 = idle && req0_valid && (!req1_valid || m_last == 1);
            e_r1 = idle && req1_valid && (!req0_valid || m_last == 0);
            if (cyc_n == m_rsp_at) begin
                m_prod = m_pend;
                m_ovf  = m_pend_ovf;
            end
            check("req0_ready", req0_ready, e_r0);
            check("req1_ready", req1_ready, e_r1);
            check("busy", busy, !idle);
            check("rsp0_valid", rsp0_valid, cyc_n == m_rsp_at && m_owner == 0);
            check("rsp1_valid", rsp1_valid, cyc_n == m_rsp_at && m_owner == 1);
            check("rsp_product", rsp_product, m_prod);
            check("mul_a", mul_a, m_a);
            check("mul_b", mul_b, m_b);
`ifdef MUL_OVF_EN
            check("rsp_ovf", rsp_ovf, m_ovf);
`endif
            if (e_r0 || e_r1) begin
                m_owner     = e_r1 ? 1 : 0;
                m_last      = m_owner;
                m_a         = e_r1 ? req1_a : req0_a;
                m_b         = e_r1 ? req1_b : req0_b;
                m_pend      = m_a * m_b;
                m_pend_ovf  = (m_pend > 16'd255);
                m_rsp_at    = cyc_n + S + 1;
                m_idle_from = cyc_n + S + 2;
            end
        end
    end

    // ---------------- helper tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(output int owner, output logic [15:0] prod, output int at);
        owner = -1;
        prod  = 16'd0;
        at    = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid) begin
                owner = rsp1_valid ? 1 : 0;
                prod  = rsp_product;
                at    = cyc_n;
                return;
            end
        end
        check("rsp_timeout", 0, 1);
    endtask

    task automatic wait_quiet();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0 && !req0_valid && !req1_valid && !busy) return;
        end
        check("quiet_timeout", 0, 1);
    endtask

    // ---------------- directed + random scenarios ----------------
    initial begin
        int          own;
        int          at;
        int          t_hs;
        int          pulses;
        logic [15:0] prod;
        int          exp_own[4];
        int          exp_prod[4];

        // Reset held two cycles
        rst_n = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        check("rst_rsp", {rsp0_valid, rsp1_valid}, 0);
        check("rst_product", rsp_product, 0);
        check("rst_mul_ab", {mul_a, mul_b}, 0);
        check("rst_busy", busy, 0);
        tick();
        rst_n = 1'b1;

        // Single request 3*5, response exactly S+1 cycles after accept
        q0.push_back({8'd3, 8'd5});
        t_hs = -1;
        for (int i = 0; i < 20 && t_hs < 0; i++) begin
            @(negedge clk);
            if (req0_valid && req0_ready) t_hs = cyc_n;
        end
        check("single_hs_seen", t_hs >= 0, 1);
        wait_rsp(own, prod, at);
        check("single_owner", own, 0);
        check("single_latency", at - t_hs, 3);
        check("single_product", prod, 15);
        wait_quiet();

        // Contention from reset: req0 255*255 first, then req1 0*7
        tick();
        rst_n = 1'b0;
        q0.push_back({8'd255, 8'd255});
        q1.push_back({8'd0, 8'd7});
        tick();
        tick();
        rst_n = 1'b1;
        wait_rsp(own, prod, at);
        check("cont_owner0", own, 0);
        check("cont_prod0", prod, 65025);
        wait_rsp(own, prod, at);
        check("cont_owner1", own, 1);
        check("cont_prod1", prod, 0);
        wait_quiet();

        // Round robin with both requesters continuously valid
        q0.push_back({8'd1, 8'd2});
        q0.push_back({8'd5, 8'd6});
        q1.push_back({8'd3, 8'd4});
        q1.push_back({8'd7, 8'd8});
        exp_own  = '{0, 1, 0, 1};
        exp_prod = '{2, 12, 30, 56};
        for (int k = 0; k < 4; k++) begin
            wait_rsp(own, prod, at);
            check("rr_owner", own, exp_own[k]);
            check("rr_prod", prod, exp_prod[k]);
        end
        wait_quiet();

        // Abort during SETTLE: no pulse, idle after reset, next tie to req0
        q0.push_back({8'd9, 8'd9});
        for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
        check("abort_busy_seen", busy, 1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_idle", busy, 0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (rsp0_valid || rsp1_valid) pulses++;
            @(negedge clk);
        end
        check("abort_no_pulse", pulses, 0);
        q0.push_back({8'd2, 8'd3});
        q1.push_back({8'd4, 8'd5});
        wait_rsp(own, prod, at);
        check("abort_tie_owner", own, 0);
        check("abort_tie_prod", prod, 6);
        wait_quiet();

`ifdef MUL_OVF_EN
        q0.push_back({8'd16, 8'd16});
        wait_rsp(own, prod, at);
        check("ovf_prod_256", prod, 256);
        check("ovf_flag_256", rsp_ovf, 1);
        q1.push_back({8'd15, 8'd17});
        wait_rsp(own, prod, at);
        check("ovf_prod_255", prod, 255);
        check("ovf_flag_255", rsp_ovf, 0);
        wait_quiet();
`endif

        // Randomized traffic with occasional withdrawals
        wd_en = 1'b1;
        for (int n = 0; n < 200; n++) begin
            int sel;
            sel = $urandom_range(0, 3);
            if (sel == 0 || sel == 2) q0.push_back(16'($urandom_range(0, 65535)));
            if (sel == 1 || sel == 2) q1.push_back(16'($urandom_range(0, 65535)));
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        wd_en = 1'b0;
        wait_quiet();
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
